crc32_attach: RTL and testbench
===============================

// Module: crc32_attach
// PURPOSE
//  Stream stage wrapped around the CRC-32 generator in the QDMA MM/ST data path.
//  - Accepts a valid/ready beat stream and drives the generator's vld/data/tlast/mty with accepted beats only,
//    so the backpressure-free generator never sees a stalled beat.
//  - Captures the generator's combinational CRC on each accepted last beat.
//  - Re-emits the beat stream through a 2-entry skid buffer, with CRC and packet byte length attached to the tlast beat.
// PARAMETERS
//  DATA_WIDTH  512                     beat width in bits (multiple of 8)
//  CRC_WIDTH   32                      CRC width, matches generator
//  MTY_BITS    $clog2(DATA_WIDTH/8)    empty-byte count width
//  LEN_WIDTH   16                      packet byte-length counter width
//  TCQ         1                       clock-to-q model delay on registered assignments
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous, active-high reset
//  s_data       in   DATA_WIDTH  upstream beat data
//  s_mty        in   MTY_BITS    empty bytes on last beat (valid only with s_tlast)
//  s_tlast      in   1           last beat of packet
//  s_valid      in   1           upstream beat valid
//  s_ready      out  1           upstream ready
//  crc_vld      out  1           to generator: beat accepted this cycle
//  crc_data     out  DATA_WIDTH  to generator: s_data passthrough
//  crc_tlast    out  1           to generator: s_tlast passthrough
//  crc_mty      out  MTY_BITS    to generator: s_mty passthrough
//  crc_in       in   CRC_WIDTH   from generator: CRC, same cycle as crc_vld
//  m_data       out  DATA_WIDTH  downstream beat data
//  m_mty        out  MTY_BITS    downstream empty bytes
//  m_tlast      out  1           downstream last beat
//  m_crc        out  CRC_WIDTH   packet CRC; zero unless m_tlast
//  m_len        out  LEN_WIDTH   packet byte length; zero unless m_tlast
//  m_len_ovf    out  1           packet length saturated; zero unless m_tlast
//  m_valid      out  1           downstream valid
//  m_ready      in   1           downstream ready
//  pkt_cnt      out  32          packets completed downstream; wraps at 2^32
// BEHAVIOUR
//  Reset values (rst=1 at posedge):
//   - s_ready=0 during reset, 1 the cycle after reset deasserts.
//   - m_valid=0; buffer empty; len_acc=0; pkt_cnt=0; all m_* payload regs 0.
//   - Reset mid-packet discards buffered beats and the partial length. Upstream must restart the packet;
//     the generator's own reset must be asserted coincidentally.
//  Accept:
//   - acc = s_valid & s_ready.
//   - crc_vld = acc, combinational. crc_data/crc_tlast/crc_mty are pure passthrough.
//  Beat bytes: DATA_WIDTH/8 when ~s_tlast; DATA_WIDTH/8 - s_mty when s_tlast.
//  Length accumulator (len_acc):
//   - On acc & ~s_tlast: len_acc <= sat(len_acc + bytes).
//   - On acc & s_tlast: beat stores len = sat(len_acc + bytes); len_acc <= 0.
//   - sat = clamp to 2^LEN_WIDTH-1 and set a sticky ovf. ovf is stored with the tlast beat and clears with len_acc.
//  CRC: on acc & s_tlast, crc_in is stored with the beat. Non-last beats store crc=0 and len=0.
//  Skid buffer: 2 entries, main (drives m_*) + skid.
//   - s_ready = ~skid_valid, registered; never combinationally dependent on m_ready.
//   - Main empty or m_ready: accepted beat loads main (or skid drains into main first, and the new beat goes to skid).
//   - Main full & ~m_ready & acc: beat goes to skid; s_ready drops the next cycle.
//   - m_ready with skid full: skid -> main, s_ready rises the next cycle.
//   - Latency s->m: 1 cycle. Full throughput 1 beat/clk when m_ready=1.
//   - m_* payload stable while m_valid & ~m_ready.
//  pkt_cnt increments on m_valid & m_ready & m_tlast.
//  Single-beat packet (s_tlast on first beat) is legal. len may be 0 when s_mty = DATA_WIDTH/8 is driven;
//  the CRC is still taken as produced.
// STRUCTURE
//  - Shared package crc_attach_pkg holds the beat_t struct {data, mty, tlast, crc, len, ovf} and the localparam
//    BEAT_BYTES = DATA_WIDTH/8.
//  - One sub-module: axis_skid_buf2, a generic 2-entry valid/ready skid buffer on beat_t.
//    Length accumulation and CRC capture stay in crc32_attach.
//  - Top level instantiates crc32_attach beside the generator and wires crc_* to it.
// TESTING
//  1. One beat, s_mty=60, tlast, m_ready=1 -> m_valid next cycle; m_len=4; m_crc matches model
//     (poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no final xor); pkt_cnt=1.
//  2. 3-beat packet, last s_mty=0, m_ready=1 -> m_len=192; m_crc=0 on beats 1-2; m_tlast only on beat 3.
//  3. m_ready=0 for 4 cycles during back-to-back beats -> exactly 2 beats buffered; s_ready=0 from the
//     cycle after the 2nd accept; no loss or duplication after m_ready=1.
//  4. LEN_WIDTH=8, 5 full beats (320 B) -> m_len=255, m_len_ovf=1; next packet 1 beat s_mty=0 -> m_len=64, ovf=0.
//  5. rst asserted mid-packet with 1 beat buffered -> m_valid=0, pkt_cnt=0 next cycle;
//     a following 1-beat packet reports m_len=64.
//  6. Random valid/ready throttling, 1000 packets of 1-20 beats -> scoreboard data/len/crc exact; pkt_cnt=1000.

Source files
------------

// File: rtl/crc_attach_pkg.sv
// Shared beat record for the CRC attach stage and its skid buffer.
// Field widths are the ceilings; narrower instances zero-extend into them.
package crc_attach_pkg;

  localparam int MAX_DATA_WIDTH = 512;
  localparam int MAX_MTY_BITS   = 6;
  localparam int MAX_CRC_WIDTH  = 32;
  localparam int MAX_LEN_WIDTH  = 16;
  localparam int BEAT_BYTES     = MAX_DATA_WIDTH / 8;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] data;
    logic [MAX_MTY_BITS-1:0]   mty;
    logic                      tlast;
    logic [MAX_CRC_WIDTH-1:0]  crc;
    logic [MAX_LEN_WIDTH-1:0]  len;
    logic                      ovf;
  } beat_t;

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry valid/ready skid buffer, 1-cycle latency, full throughput.
// s_rdy is registered (~skid full) so upstream never sees a combinational path from m_rdy.
module axis_skid_buf2
  import crc_attach_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic s_vld,
  output logic s_rdy,
  input  T     s_dat,
  output logic m_vld,
  input  logic m_rdy,
  output T     m_dat
);

  T     main_q, main_d;
  T     skid_q, skid_d;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic rdy_q;
  logic acc;
  logic main_free;

  assign acc       = s_vld & rdy_q;
  assign main_free = ~main_vld_q | m_rdy;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (main_free) begin
      // Skid always drains first so beat order is preserved.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = acc;
        if (acc) skid_d = s_dat;
      end else begin
        main_vld_d = acc;
        if (acc) main_d = s_dat;
      end
    end else if (acc) begin
      skid_d     = s_dat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= ~skid_vld_d;
    end
  end

  assign s_rdy = rdy_q;
  assign m_vld = main_vld_q;
  assign m_dat = main_q;

endmodule

// File: rtl/crc32_attach.sv
// Feeds accepted beats to the CRC generator, attaches CRC/length on tlast; 1-cycle latency.
// Backpressure absorbed by a 2-entry skid buffer; s_ready is registered.
module crc32_attach
  import crc_attach_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int CRC_WIDTH  = 32,
  parameter int MTY_BITS   = $clog2(DATA_WIDTH / 8),
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [MTY_BITS-1:0]   s_mty,
  input  logic                  s_tlast,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  crc_vld,
  output logic [DATA_WIDTH-1:0] crc_data,
  output logic                  crc_tlast,
  output logic [MTY_BITS-1:0]   crc_mty,
  input  logic [CRC_WIDTH-1:0]  crc_in,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [MTY_BITS-1:0]   m_mty,
  output logic                  m_tlast,
  output logic [CRC_WIDTH-1:0]  m_crc,
  output logic [LEN_WIDTH-1:0]  m_len,
  output logic                  m_len_ovf,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [31:0]           pkt_cnt
);

  localparam int BYTES = DATA_WIDTH / 8;
  // Wide enough to hold a saturated length plus one full beat without wrapping.
  localparam int SUM_W = LEN_WIDTH + $clog2(BYTES + 1);
  localparam logic [SUM_W-1:0] LEN_MAX = SUM_W'({LEN_WIDTH{1'b1}});

  logic                 acc;
  logic [SUM_W-1:0]     beat_bytes;
  logic [SUM_W-1:0]     len_sum;
  logic                 sum_ovf;
  logic [LEN_WIDTH-1:0] len_sat;
  logic                 ovf_next;
  logic [LEN_WIDTH-1:0] len_acc;
  logic                 len_ovf;
  beat_t                in_beat;
  beat_t                out_beat;

  assign acc       = s_valid & s_ready;
  assign crc_vld   = acc;
  assign crc_data  = s_data;
  assign crc_tlast = s_tlast;
  assign crc_mty   = s_mty;

  always_comb begin
    beat_bytes = s_tlast ? (SUM_W'(BYTES) - SUM_W'(s_mty)) : SUM_W'(BYTES);
    len_sum    = SUM_W'(len_acc) + beat_bytes;
    sum_ovf    = len_sum > LEN_MAX;
    len_sat    = sum_ovf ? {LEN_WIDTH{1'b1}} : len_sum[LEN_WIDTH-1:0];
    ovf_next   = len_ovf | sum_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_acc <= '0;
      len_ovf <= 1'b0;
    end else if (acc) begin
      if (s_tlast) begin
        len_acc <= '0;
        len_ovf <= 1'b0;
      end else begin
        len_acc <= len_sat;
        len_ovf <= ovf_next;
      end
    end
  end

  // CRC, length and overflow ride only on the last beat; other beats carry zeros.
  always_comb begin
    in_beat       = '0;
    in_beat.data  = MAX_DATA_WIDTH'(s_data);
    in_beat.mty   = MAX_MTY_BITS'(s_mty);
    in_beat.tlast = s_tlast;
    if (s_tlast) begin
      in_beat.crc = MAX_CRC_WIDTH'(crc_in);
      in_beat.len = MAX_LEN_WIDTH'(len_sat);
      in_beat.ovf = ovf_next;
    end
  end

  axis_skid_buf2 #(
    .T(beat_t)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .s_vld (s_valid),
    .s_rdy (s_ready),
    .s_dat (in_beat),
    .m_vld (m_valid),
    .m_rdy (m_ready),
    .m_dat (out_beat)
  );

  assign m_data    = out_beat.data[DATA_WIDTH-1:0];
  assign m_mty     = out_beat.mty[MTY_BITS-1:0];
  assign m_tlast   = out_beat.tlast;
  assign m_crc     = out_beat.crc[CRC_WIDTH-1:0];
  assign m_len     = out_beat.len[LEN_WIDTH-1:0];
  assign m_len_ovf = out_beat.ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (m_valid & m_ready & m_tlast) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_crc32_attach.sv
// Bench for crc32_attach: a 16-bit and an 8-bit length instance share stimulus and the CRC generator model.
module tb_crc32_attach;

  localparam int DW = 512;
  localparam int BB = DW / 8;
  localparam int MB = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic [MB-1:0] s_mty;
  logic          s_tlast, s_valid, m_ready;

  logic          s_ready, crc_vld, crc_tlast, m_tlast, m_len_ovf, m_valid;
  logic [DW-1:0] crc_data, m_data;
  logic [MB-1:0] crc_mty, m_mty;
  logic [31:0]   crc_in, m_crc, pkt_cnt;
  logic [15:0]   m_len;

  logic          s_ready8, crc_vld8, crc_tlast8, m_tlast8, m_len_ovf8, m_valid8;
  logic [DW-1:0] crc_data8, m_data8;
  logic [MB-1:0] crc_mty8, m_mty8;
  logic [31:0]   m_crc8, pkt_cnt8;
  logic [7:0]    m_len8;

  always #5 clk = ~clk;

  crc32_attach dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_mty(s_mty), .s_tlast(s_tlast),
    .s_valid(s_valid), .s_ready(s_ready), .crc_vld(crc_vld), .crc_data(crc_data),
    .crc_tlast(crc_tlast), .crc_mty(crc_mty), .crc_in(crc_in), .m_data(m_data),
    .m_mty(m_mty), .m_tlast(m_tlast), .m_crc(m_crc), .m_len(m_len),
    .m_len_ovf(m_len_ovf), .m_valid(m_valid), .m_ready(m_ready), .pkt_cnt(pkt_cnt)
  );

  crc32_attach #(.LEN_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_mty(s_mty), .s_tlast(s_tlast),
    .s_valid(s_valid), .s_ready(s_ready8), .crc_vld(crc_vld8), .crc_data(crc_data8),
    .crc_tlast(crc_tlast8), .crc_mty(crc_mty8), .crc_in(crc_in), .m_data(m_data8),
    .m_mty(m_mty8), .m_tlast(m_tlast8), .m_crc(m_crc8), .m_len(m_len8),
    .m_len_ovf(m_len_ovf8), .m_valid(m_valid8), .m_ready(m_ready), .pkt_cnt(pkt_cnt8)
  );

  // CRC-32 byte step: poly 04C11DB7, MSB-first, no reflection.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ b[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_beat(input logic [31:0] c, input logic [DW-1:0] d, input int n);
    for (int k = 0; k < n; k++) c = crc_byte(c, d[8*k +: 8]);
    return c;
  endfunction

  // Generator model: running CRC across beats, combinational result on the accepted beat.
  logic [31:0] gen_state;
  always_comb crc_in = crc_beat(gen_state, crc_data, crc_tlast ? BB - int'(crc_mty) : BB);
  always @(posedge clk) begin
    if (rst)          gen_state <= 32'hFFFFFFFF;
    else if (crc_vld) gen_state <= crc_tlast ? 32'hFFFFFFFF : crc_in;
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [MB-1:0] mty;
    logic          tlast;
    logic [31:0]   crc;
    logic [15:0]   len;
    logic          ovf;
    logic [7:0]    len8;
    logic          ovf8;
  } exp_t;

  typedef struct {
    int   nbeats;
    int   last_mty;
    int   len16;
    logic ovf16;
    int   len8;
    logic ovf8;
  } vec_t;

  exp_t        sb[$];
  logic [7:0]  pkt_bytes[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_pkt = 0;
  logic        accepted = 1'b0;
  logic        rand_rdy = 1'b0;
  logic [15:0] last_len;
  logic        last_ovf;
  logic [7:0]  last_len8;
  logic        last_ovf8;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic on_accept();
    exp_t e;
    int n, total;
    logic [31:0] c;
    n = s_tlast ? BB - int'(s_mty) : BB;
    for (int k = 0; k < n; k++) pkt_bytes.push_back(s_data[8*k +: 8]);
    e = '{s_data, s_mty, s_tlast, 32'd0, 16'd0, 1'b0, 8'd0, 1'b0};
    if (s_tlast) begin
      total = pkt_bytes.size();
      c = 32'hFFFFFFFF;
      foreach (pkt_bytes[i]) c = crc_byte(c, pkt_bytes[i]);
      e.crc  = c;
      e.len  = (total > 65535) ? 16'hFFFF : 16'(total);
      e.ovf  = (total > 65535);
      e.len8 = (total > 255) ? 8'hFF : 8'(total);
      e.ovf8 = (total > 255);
      pkt_bytes.delete();
    end
    sb.push_back(e);
  endtask

  task automatic on_transfer();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_beat: got beat data %0h expected none", m_data);
      return;
    end
    e = sb.pop_front();
    check("m_data", m_data, e.data);
    check("m_mty", m_mty, e.mty);
    check("m_tlast", m_tlast, e.tlast);
    check("m_crc", m_crc, e.crc);
    check("m_len", m_len, e.len);
    check("m_len_ovf", m_len_ovf, e.ovf);
    check("m_valid8", m_valid8, 1);
    check("m_len8", m_len8, e.len8);
    check("m_len_ovf8", m_len_ovf8, e.ovf8);
    if (m_tlast) begin
      exp_pkt++;
      last_len  = m_len;
      last_ovf  = m_len_ovf;
      last_len8 = m_len8;
      last_ovf8 = m_len_ovf8;
    end
  endtask

  // Observe handshakes 1 unit before the edge, advance to 1 unit after it.
  task automatic cycle();
    #1;
    accepted = 1'b0;
    if (!rst && s_valid && s_ready) begin
      on_accept();
      accepted = 1'b1;
    end
    if (!rst && m_valid && m_ready) on_transfer();
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic new_beat(input logic tlast, input int mty);
    for (int w = 0; w < DW / 32; w++) s_data[32*w +: 32] = $urandom();
    s_tlast = tlast;
    s_mty   = tlast ? MB'(mty) : '0;
    s_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int t = 0;
    do begin
      cycle();
      t++;
    end while (!accepted && t < 500);
    if (!accepted) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no accept expected accept within 500 cycles");
    end
  endtask

  task automatic send_pkt(input int n, input int last_mty, input logic idle, input logic lat_chk);
    for (int b = 0; b < n; b++) begin
      if (idle && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) cycle();
      end
      new_beat(b == n - 1, last_mty);
      wait_accept();
      if (lat_chk && b == 0) check("latency_m_valid", m_valid, 1);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    s_valid = 1'b0;
    while ((sb.size() != 0 || m_valid) && t < 500) begin
      cycle();
      t++;
    end
    if (sb.size() != 0 || m_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tv[10];
    int   acc_cnt;
    logic [31:0] start_cnt;

    tv[0] = '{1,    60, 4,     1'b0, 4,   1'b0};
    tv[1] = '{3,    0,  192,   1'b0, 192, 1'b0};
    tv[2] = '{5,    0,  320,   1'b0, 255, 1'b1};
    tv[3] = '{1,    0,  64,    1'b0, 64,  1'b0};
    tv[4] = '{2,    10, 118,   1'b0, 118, 1'b0};
    tv[5] = '{4,    1,  255,   1'b0, 255, 1'b0};
    tv[6] = '{5,    63, 257,   1'b0, 255, 1'b1};
    tv[7] = '{1024, 1,  65535, 1'b0, 255, 1'b1};
    tv[8] = '{1025, 0,  65535, 1'b1, 255, 1'b1};
    tv[9] = '{1,    63, 1,     1'b0, 1,   1'b0};

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    s_data = '0; s_mty = '0; s_tlast = 1'b0;
    repeat (2) cycle();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_m_len", m_len, 0);
    check("rst_m_crc", m_crc, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b0;
    cycle();
    check("post_rst_s_ready", s_ready, 1);
    m_ready = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send_pkt(tv[i].nbeats, tv[i].last_mty, 1'b0, 1'b1);
      drain();
      check("tbl_len", last_len, tv[i].len16);
      check("tbl_ovf", last_ovf, tv[i].ovf16);
      check("tbl_len8", last_len8, tv[i].len8);
      check("tbl_ovf8", last_ovf8, tv[i].ovf8);
    end
    check("tbl_pkt_cnt", pkt_cnt, 10);

    // Stall downstream while upstream streams: exactly main+skid fill.
    m_ready = 1'b0;
    acc_cnt = 0;
    new_beat(1'b0, 0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (accepted) begin
        acc_cnt++;
        new_beat(acc_cnt == 3, 0);
      end
    end
    check("stall_accepts", acc_cnt, 2);
    check("stall_s_ready", s_ready, 0);
    check("stall_m_valid", m_valid, 1);
    m_ready = 1'b1;
    while (acc_cnt < 4) begin
      wait_accept();
      acc_cnt++;
      if (acc_cnt < 4) new_beat(acc_cnt == 3, 0);
    end
    s_valid = 1'b0;
    drain();
    check("stall_len", last_len, 256);

    start_cnt = pkt_cnt;
    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++)
      send_pkt($urandom_range(1, 20), $urandom_range(0, 63), 1'b1, 1'b0);
    drain();
    rand_rdy = 1'b0;
    m_ready = 1'b1;
    check("rand_pkt_cnt", pkt_cnt - start_cnt, 1000);
    check("rand_pkt_cnt_model", pkt_cnt, exp_pkt);

    // Reset with one beat of an unfinished packet sitting in the buffer.
    m_ready = 1'b0;
    new_beat(1'b0, 0);
    wait_accept();
    s_valid = 1'b0;
    check("pre_rst_m_valid", m_valid, 1);
    rst = 1'b1;
    cycle();
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    check("mid_rst_s_ready", s_ready, 0);
    sb.delete();
    pkt_bytes.delete();
    exp_pkt = 0;
    rst = 1'b0;
    cycle();
    check("mid_rst_s_ready_up", s_ready, 1);
    m_ready = 1'b1;
    send_pkt(1, 0, 1'b0, 1'b1);
    drain();
    check("after_rst_len", last_len, 64);
    check("after_rst_pkt_cnt", pkt_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
